// File: rtl/l2_line_beat_ser_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_beat_ser_if
// Brief    : Wide-line in / narrow-beat out valid/retry bundle for l2_line_beat_ser.
// Revision : 1.0
// ============================================================================
interface l2_line_beat_ser_if #(
    parameter int NLANES     = 8,
    parameter int LANE_W     = 64,
    parameter int BEAT_LANES = 2,
    parameter int HDR_W      = 64,
    parameter int CNT_W      = 16
);
    localparam int NBEATS = NLANES / BEAT_LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic                         in_valid;
    logic                         in_retry;
    logic [HDR_W-1:0]             in_hdr;
    logic [NLANES*LANE_W-1:0]     in_line;
    logic                         in_nodata;

    logic                         out_valid;
    logic                         out_retry;
    logic [HDR_W-1:0]             out_hdr;
    logic [BEAT_LANES*LANE_W-1:0] out_data;
    logic [BW-1:0]                out_beat;
    logic                         out_first;
    logic                         out_last;

    logic [CNT_W-1:0]             stat_nlines;
    logic [CNT_W-1:0]             stat_nstall;

    // master: upstream producer plus downstream consumer; slave: the serializer
    modport master (
        output in_valid, in_hdr, in_line, in_nodata, out_retry,
        input  in_retry, out_valid, out_hdr, out_data, out_beat,
               out_first, out_last, stat_nlines, stat_nstall
    );

    modport slave (
        input  in_valid, in_hdr, in_line, in_nodata, out_retry,
        output in_retry, out_valid, out_hdr, out_data, out_beat,
               out_first, out_last, stat_nlines, stat_nstall
    );
endinterface
`default_nettype wire

// File: rtl/l2_line_beat_ser.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_beat_ser
// Brief    : Serializes one header + full cache line into NBEATS narrow beats.
// Revision : 1.0
// ============================================================================
module l2_line_beat_ser #(
    parameter int NLANES     = 8,
    parameter int LANE_W     = 64,
    parameter int BEAT_LANES = 2,
    parameter int HDR_W      = 64,
    parameter int CNT_W      = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    l2_line_beat_ser_if.slave   bus
);
    localparam int NBEATS = NLANES / BEAT_LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_W = BEAT_LANES * LANE_W;

    localparam logic [0:0]       c_idle      = 1'b0;
    localparam logic [0:0]       c_send      = 1'b1;
    localparam logic [BW-1:0]    c_last_beat = BW'(NBEATS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic [HDR_W-1:0]         r_hdr;
    logic [NLANES*LANE_W-1:0] r_line;
    logic                     r_nodata;
    logic [BW-1:0]            r_beat;
    logic [CNT_W-1:0]         r_nlines;
    logic [CNT_W-1:0]         r_nstall;

    logic                     w_out_valid;
    logic                     w_last;
    logic                     w_in_retry;
    logic                     w_accept;
    logic                     w_beat_xfer;
    logic                     w_stall;
    logic [BEAT_W-1:0]        w_data;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_nxt = c_send;
            c_send:  if (w_beat_xfer && w_last && !w_accept) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output / handshake logic; in_retry opens only as the last beat leaves
    always_comb begin
        w_out_valid = (r_state == c_send);
        w_last      = r_nodata || (r_beat == c_last_beat);
        w_in_retry  = reset || (w_out_valid && !(w_last && !bus.out_retry));
        w_accept    = bus.in_valid && !w_in_retry;
        w_beat_xfer = w_out_valid && !bus.out_retry;
        w_stall     = w_out_valid && bus.out_retry;
    end

    // Beat selection; header-only messages carry an all-zero payload
    always_comb begin
        w_data = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (!r_nodata && (r_beat == BW'(b))) begin
                w_data = r_line[b*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr    <= '0;
            r_line   <= '0;
            r_nodata <= 1'b0;
            r_beat   <= '0;
            r_nlines <= '0;
            r_nstall <= '0;
        end else begin
            if (w_accept) begin
                r_hdr    <= bus.in_hdr;
                r_line   <= bus.in_line;
                r_nodata <= bus.in_nodata;
                r_beat   <= '0;
            end else if (w_beat_xfer && !w_last) begin
                r_beat   <= r_beat + 1'b1;
            end
            if (w_beat_xfer && w_last && (r_nlines != c_cnt_max)) begin
                r_nlines <= r_nlines + 1'b1;
            end
            if (w_stall && (r_nstall != c_cnt_max)) begin
                r_nstall <= r_nstall + 1'b1;
            end
        end
    end

    assign bus.in_retry    = w_in_retry;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_hdr     = r_hdr;
    assign bus.out_data    = w_data;
    assign bus.out_beat    = r_beat;
    assign bus.out_first   = w_out_valid && (r_beat == '0);
    assign bus.out_last    = w_out_valid && w_last;
    assign bus.stat_nlines = r_nlines;
    assign bus.stat_nstall = r_nstall;

endmodule
`default_nettype wire

// File: tb/tb_l2_line_beat_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_line_beat_ser
// Brief    : Directed self-checking bench for l2_line_beat_ser (2-lane and 8-lane beats).
// Revision : 1.0
// ============================================================================
module tb_l2_line_beat_ser;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [511:0] line_a;
    logic [511:0] line_b;

    always #5 clk = ~clk;

    l2_line_beat_ser_if #(.NLANES(8), .LANE_W(64), .BEAT_LANES(2), .HDR_W(64), .CNT_W(16)) bus0 ();
    l2_line_beat_ser_if #(.NLANES(8), .LANE_W(64), .BEAT_LANES(8), .HDR_W(64), .CNT_W(16)) bus1 ();

    l2_line_beat_ser #(.NLANES(8), .LANE_W(64), .BEAT_LANES(2), .HDR_W(64), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    l2_line_beat_ser #(.NLANES(8), .LANE_W(64), .BEAT_LANES(8), .HDR_W(64), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [511:0] mk_line(input int base);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*64 +: 64] = 64'(base + i);
        return r;
    endfunction

    // Lanes hold base+i, so beat k carries lanes 2k (LSBs) and 2k+1
    function automatic logic [127:0] pair(input int base, input int k);
        return {64'(base + 2*k + 1), 64'(base + 2*k)};
    endfunction

    task automatic check_beat(input string tag, input int base, input int k,
                              input logic [63:0] hdr, input bit nodata);
        chk({tag, "_valid"}, 512'(bus0.out_valid), 512'(1));
        chk({tag, "_beat"},  512'(bus0.out_beat),  512'(k));
        chk({tag, "_first"}, 512'(bus0.out_first), 512'(k == 0));
        chk({tag, "_last"},  512'(bus0.out_last),  512'(nodata || k == 3));
        chk({tag, "_data"},  512'(bus0.out_data),  nodata ? 512'(0) : 512'(pair(base, k)));
        chk({tag, "_hdr"},   512'(bus0.out_hdr),   512'(hdr));
    endtask

    initial begin
        line_a = mk_line(32'h10);
        line_b = mk_line(32'h20);
        reset = 1'b1;
        bus0.in_valid = 1'b1; bus0.in_hdr = 64'h55; bus0.in_line = line_a;
        bus0.in_nodata = 1'b0; bus0.out_retry = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_hdr = '0; bus1.in_line = '0;
        bus1.in_nodata = 1'b0; bus1.out_retry = 1'b0;

        // Reset values; in_valid held during reset must not be taken
        tick();
        chk("rst_valid",  512'(bus0.out_valid),   512'(0));
        chk("rst_beat",   512'(bus0.out_beat),    512'(0));
        chk("rst_first",  512'(bus0.out_first),   512'(0));
        chk("rst_last",   512'(bus0.out_last),    512'(0));
        chk("rst_hdr",    512'(bus0.out_hdr),     512'(0));
        chk("rst_data",   512'(bus0.out_data),    512'(0));
        chk("rst_nlines", 512'(bus0.stat_nlines), 512'(0));
        chk("rst_nstall", 512'(bus0.stat_nstall), 512'(0));
        chk("rst_retry",  512'(bus0.in_retry),    512'(1));
        reset = 1'b0; bus0.in_valid = 1'b0;
        tick();
        chk("idle_valid", 512'(bus0.out_valid), 512'(0));
        chk("idle_retry", 512'(bus0.in_retry),  512'(0));

        // 1: plain line, four consecutive beats
        bus0.in_valid = 1'b1; bus0.in_hdr = 64'h1111; bus0.in_line = line_a;
        tick(); bus0.in_valid = 1'b0; settle();
        check_beat("t1_b0", 32'h10, 0, 64'h1111, 1'b0);
        chk("t1_b0_retry", 512'(bus0.in_retry), 512'(1));
        tick(); check_beat("t1_b1", 32'h10, 1, 64'h1111, 1'b0);
        tick(); check_beat("t1_b2", 32'h10, 2, 64'h1111, 1'b0);
        tick(); check_beat("t1_b3", 32'h10, 3, 64'h1111, 1'b0);
        chk("t1_b3_retry", 512'(bus0.in_retry), 512'(0));
        tick();
        chk("t1_idle",   512'(bus0.out_valid),   512'(0));
        chk("t1_nlines", 512'(bus0.stat_nlines), 512'(1));
        chk("t1_nstall", 512'(bus0.stat_nstall), 512'(0));

        // 2: three stall cycles on beat 1
        bus0.in_valid = 1'b1; bus0.in_hdr = 64'h2222; bus0.in_line = line_a;
        tick(); bus0.in_valid = 1'b0; settle();
        check_beat("t2_b0", 32'h10, 0, 64'h2222, 1'b0);
        tick(); bus0.out_retry = 1'b1; settle();
        check_beat("t2_b1_s0", 32'h10, 1, 64'h2222, 1'b0);
        chk("t2_retry0", 512'(bus0.in_retry), 512'(1));
        tick(); check_beat("t2_b1_s1", 32'h10, 1, 64'h2222, 1'b0);
        chk("t2_nstall1", 512'(bus0.stat_nstall), 512'(1));
        chk("t2_retry1", 512'(bus0.in_retry), 512'(1));
        tick(); check_beat("t2_b1_s2", 32'h10, 1, 64'h2222, 1'b0);
        chk("t2_nstall2", 512'(bus0.stat_nstall), 512'(2));
        tick(); bus0.out_retry = 1'b0; settle();
        check_beat("t2_b1_s3", 32'h10, 1, 64'h2222, 1'b0);
        chk("t2_nstall3", 512'(bus0.stat_nstall), 512'(3));
        chk("t2_retry3", 512'(bus0.in_retry), 512'(1));
        tick(); check_beat("t2_b2", 32'h10, 2, 64'h2222, 1'b0);
        tick(); check_beat("t2_b3", 32'h10, 3, 64'h2222, 1'b0);
        tick();
        chk("t2_idle",   512'(bus0.out_valid),   512'(0));
        chk("t2_nlines", 512'(bus0.stat_nlines), 512'(2));
        chk("t2_nstall", 512'(bus0.stat_nstall), 512'(3));

        // 3: header-only message
        bus0.in_valid = 1'b1; bus0.in_nodata = 1'b1; bus0.in_hdr = 64'hABCD; bus0.in_line = line_a;
        tick(); bus0.in_valid = 1'b0; bus0.in_nodata = 1'b0; settle();
        check_beat("t3_nd", 32'h10, 0, 64'hABCD, 1'b1);
        chk("t3_retry", 512'(bus0.in_retry), 512'(0));
        tick();
        chk("t3_idle",   512'(bus0.out_valid),   512'(0));
        chk("t3_nlines", 512'(bus0.stat_nlines), 512'(3));

        // 4: back-to-back lines, second header on beat 4
        bus0.in_valid = 1'b1; bus0.in_hdr = 64'h4444; bus0.in_line = line_a;
        tick(); bus0.in_hdr = 64'h5555; bus0.in_line = line_b; settle();
        check_beat("t4_a0", 32'h10, 0, 64'h4444, 1'b0);
        chk("t4_a0_retry", 512'(bus0.in_retry), 512'(1));
        tick(); check_beat("t4_a1", 32'h10, 1, 64'h4444, 1'b0);
        tick(); check_beat("t4_a2", 32'h10, 2, 64'h4444, 1'b0);
        tick(); check_beat("t4_a3", 32'h10, 3, 64'h4444, 1'b0);
        chk("t4_a3_retry", 512'(bus0.in_retry), 512'(0));
        tick(); bus0.in_valid = 1'b0; settle();
        check_beat("t4_b0", 32'h20, 0, 64'h5555, 1'b0);
        tick(); check_beat("t4_b1", 32'h20, 1, 64'h5555, 1'b0);
        tick(); check_beat("t4_b2", 32'h20, 2, 64'h5555, 1'b0);
        tick(); check_beat("t4_b3", 32'h20, 3, 64'h5555, 1'b0);
        tick();
        chk("t4_idle",   512'(bus0.out_valid),   512'(0));
        chk("t4_nlines", 512'(bus0.stat_nlines), 512'(5));

        // 5: reset during beat 2 drops the message
        bus0.in_valid = 1'b1; bus0.in_hdr = 64'h6666; bus0.in_line = line_a;
        tick(); bus0.in_valid = 1'b0; settle();
        check_beat("t5_b0", 32'h10, 0, 64'h6666, 1'b0);
        tick(); check_beat("t5_b1", 32'h10, 1, 64'h6666, 1'b0);
        tick(); check_beat("t5_b2", 32'h10, 2, 64'h6666, 1'b0);
        reset = 1'b1; settle();
        chk("t5_rst_retry", 512'(bus0.in_retry), 512'(1));
        tick();
        chk("t5_valid",  512'(bus0.out_valid),   512'(0));
        chk("t5_nlines", 512'(bus0.stat_nlines), 512'(0));
        chk("t5_nstall", 512'(bus0.stat_nstall), 512'(0));
        chk("t5_beat",   512'(bus0.out_beat),    512'(0));
        chk("t5_hdr",    512'(bus0.out_hdr),     512'(0));
        reset = 1'b0;
        tick();
        chk("t5_post1_valid", 512'(bus0.out_valid), 512'(0));
        tick();
        chk("t5_post2_valid", 512'(bus0.out_valid), 512'(0));

        // 6: full-width beat instance
        bus1.in_valid = 1'b1; bus1.in_hdr = 64'h7777; bus1.in_line = line_b; settle();
        chk("t6_in_retry", 512'(bus1.in_retry), 512'(0));
        tick(); bus1.in_valid = 1'b0; settle();
        chk("t6_valid", 512'(bus1.out_valid), 512'(1));
        chk("t6_first", 512'(bus1.out_first), 512'(1));
        chk("t6_last",  512'(bus1.out_last),  512'(1));
        chk("t6_beat",  512'(bus1.out_beat),  512'(0));
        chk("t6_data",  bus1.out_data,        line_b);
        chk("t6_hdr",   512'(bus1.out_hdr),   512'(64'h7777));
        tick();
        chk("t6_idle",   512'(bus1.out_valid),   512'(0));
        chk("t6_nlines", 512'(bus1.stat_nlines), 512'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/l2_line_beat_ser.md
Name: l2_line_beat_ser

Overview:
Parametrised serializer for the L2 valid/retry channels that carry a full cache line (l2tol1_snack, l2todr_disp).
- Accepts one header plus a flattened line of NLANES lanes in a single transfer.
- Emits the line as NBEATS = NLANES/BEAT_LANES beats on a narrower valid/retry channel.
- Header-only messages go out as a single beat.
- Sits between l2cache_pipe output channels and narrower links toward L1 or the directory.

Parameters:
NLANES, 8, lanes per line (line7..line0 map to lanes 7..0).
LANE_W, 64, bits per lane.
BEAT_LANES, 2, lanes per output beat; must divide NLANES. NBEATS=NLANES/BEAT_LANES; BW=max(1,clog2(NBEATS)).
HDR_W, 64, opaque header width (dcid/l2id/snack/paddr etc. packed by the user).
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input message valid
in_retry  out  1  input back-pressure
in_hdr  in  HDR_W  header, captured on accept
in_line  in  NLANES*LANE_W  line; lane 0 (line0) at LSBs
in_nodata  in  1  1 = header-only message, line ignored
out_valid  out  1  beat valid
out_retry  in  1  downstream back-pressure
out_hdr  out  HDR_W  header of the current message, stable for all its beats
out_data  out  BEAT_LANES*LANE_W  beat payload
out_beat  out  BW  beat index, 0..NBEATS-1
out_first  out  1  first beat of message
out_last  out  1  last beat of message
stat_nlines  out  CNT_W  messages completed, saturating
stat_nstall  out  CNT_W  cycles with out_valid&&out_retry, saturating

Behaviour:
- Handshake: a transfer occurs on a channel when valid && !retry. The sender holds valid and payload stable while retry=1.
- Reset (synchronous): state=IDLE; out_valid=0; out_beat=0; out_first=0; out_last=0; out_hdr=0; out_data=0; both counters=0; in_retry=1 during the reset cycle.
- Reset mid-message drops the in-flight message. No partial beats follow reset.
- FSM states:
  - IDLE: in_retry=0; out_valid=0.
  - SEND: out_valid=1.
- IDLE: on in_valid, capture hdr, line and nodata into the holding register; set beat=0; go to SEND next cycle. Latency: accept in cycle N, first beat valid in N+1.
- SEND beat k:
  - out_data = lanes [k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1]; the lowest lane sits at the LSBs.
  - out_first = (k==0).
  - out_last = nodata || (k==NBEATS-1).
  - For nodata, out_data = 0 and a single beat k=0 is sent.
- On beat transfer with !out_last: increment k.
- On beat transfer with out_last: increment stat_nlines.
  - If in_valid in the same cycle: capture the new message, k=0, stay in SEND. This gives back-to-back messages with no bubble.
  - Otherwise go to IDLE.
- in_retry in SEND = !(out_valid && out_last && !out_retry). This path is combinational from out_retry.
- While out_retry=1, all out_* signals are held stable.
- stat_nstall increments every cycle that out_valid&&out_retry. Both counters saturate at 2^CNT_W-1 and do not wrap.
- If BEAT_LANES==NLANES: every message is one beat with first=last=1 and out_beat=0.
- If in_valid is asserted during reset: it is not accepted.

Test Plan:
1. Defaults; send a line with lane i = 0x10+i, no stalls. Expect 4 beats in consecutive cycles:
   - out_data = {0x11,0x10}, {0x13,0x12}, {0x15,0x14}, {0x17,0x16};
   - out_beat = 0..3; first only on beat 0, last only on beat 3;
   - stat_nlines = 1.
2. Same line with out_retry=1 for 3 cycles during beat 1. Expect beat 1 held unchanged for 3 cycles, in_retry=1 throughout, stat_nstall=3, then beats 2 and 3 follow.
3. in_nodata=1, in_hdr=0xABCD. Expect one beat with out_hdr=0xABCD, out_data=0, first=last=1; returns to IDLE the next cycle.
4. Two lines presented back-to-back with in_valid held high. Expect 8 contiguous beats with no idle cycle, and the second header appears on beat 4.
5. Assert reset during beat 2 of a line. Expect out_valid=0 the next cycle, counters=0, in_retry=1 during reset, and no remaining beats.
6. BEAT_LANES=8 instance with any line. Expect a single 512-bit beat with first=last=1 and out_beat=0, equal to in_line.
